// File: rtl/debug_trace_unit.sv
// Debug tap beside the core: per-stage PC/opcode model, breakpoint halt/resume FSM,
// and a first-word-fall-through trace FIFO of register write-backs.
module debug_trace_unit #(
   parameter int unsigned DATA    = 32,
   parameter int unsigned ADDRESS = 9,
   parameter int unsigned STAGES  = 5,
   parameter int unsigned NUM_BP  = 2,
   parameter int unsigned DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable_debug,
   input  logic                          stall,
   input  logic                          flush,
   input  logic [ADDRESS-1:0]            pc_fetch,
   input  logic [6:0]                    opcode,
   input  logic [NUM_BP*ADDRESS-1:0]     bp_addr,
   input  logic [NUM_BP-1:0]             bp_en,
   input  logic                          resume,
   input  logic                          wb_valid,
   input  logic [4:0]                    wb_reg_num,
   input  logic [DATA-1:0]               wb_data,
   input  logic                          trace_ready,
   input  logic                          trace_clear,
   output logic [STAGES*ADDRESS-1:0]     stage_pc,
   output logic [STAGES*7-1:0]           stage_opcode,
   output logic                          halt_req,
   output logic [1:0]                    dbg_state,
   output logic [2:0]                    bp_hit_idx,
   output logic                          trace_valid,
   output logic [ADDRESS+5+DATA-1:0]     trace_data,
   output logic [$clog2(DEPTH):0]        trace_count,
   output logic                          trace_overflow
);

   localparam int unsigned TW = ADDRESS + 5 + DATA;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic                 r_halt;
   logic [2:0]           r_bp_idx;
   logic                 r_resume_mask;
   logic                 w_take_bp;
   logic                 w_hit;
   logic [2:0]           w_hit_idx;
   logic                 w_advance;

   logic [ADDRESS-1:0]   r_pc [STAGES];
   logic [6:0]           r_op [STAGES];

   logic [TW-1:0]        r_mem [DEPTH];
   logic [PW-1:0]        r_wptr;
   logic [PW-1:0]        r_rptr;
   logic [CW-1:0]        r_count;
   logic                 r_overflow;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_wr;

   assign w_advance = !stall && !r_halt;

   // Pipeline model; flush zeroes the two front stages while the back still drains.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < STAGES; k++) begin
            r_pc[k] <= '0;
            r_op[k] <= '0;
         end
      end else begin
         if (flush) begin
            r_pc[0] <= '0;
            r_op[0] <= '0;
            r_pc[1] <= '0;
            r_op[1] <= '0;
         end else if (w_advance) begin
            r_pc[0] <= pc_fetch;
            r_op[0] <= opcode;
            r_pc[1] <= r_pc[0];
            r_op[1] <= r_op[0];
         end
         if (w_advance) begin
            for (int k = 2; k < STAGES; k++) begin
               r_pc[k] <= r_pc[k-1];
               r_op[k] <= r_op[k-1];
            end
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      assign stage_pc[k*ADDRESS +: ADDRESS] = r_pc[k];
      assign stage_opcode[k*7 +: 7]         = r_op[k];
   end

   // Lowest-numbered enabled comparator wins.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (bp_en[i] && (pc_fetch == bp_addr[i*ADDRESS +: ADDRESS])) begin
            w_hit     = 1'b1;
            w_hit_idx = 3'(i);
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_take_bp    = 1'b0;
      case (r_state)
         ST_IDLE:   w_state_next = ST_ARMED;
         ST_ARMED: begin
            if (w_hit && !stall && !r_resume_mask) begin
               w_state_next = ST_HALTED;
               w_take_bp    = 1'b1;
            end
         end
         ST_HALTED: if (resume) w_state_next = ST_ARMED;
         default:   w_state_next = ST_IDLE;
      endcase
      if (!enable_debug) begin
         w_state_next = ST_IDLE;
         w_take_bp    = 1'b0;
      end
   end

   // halt_req tracks the next state so it rises/falls together with HALTED.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_halt        <= 1'b0;
         r_bp_idx      <= '0;
         r_resume_mask <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_halt        <= (w_state_next == ST_HALTED);
         r_resume_mask <= (r_state == ST_HALTED) && (w_state_next == ST_ARMED);
         if (w_take_bp) r_bp_idx <= w_hit_idx;
      end
   end

   assign halt_req   = r_halt;
   assign dbg_state  = r_state;
   assign bp_hit_idx = r_bp_idx;

   assign w_push = (r_state != ST_IDLE) && wb_valid && (wb_reg_num != 5'd0);
   assign w_pop  = (r_count != '0) && trace_ready;
   assign w_full = (r_count == CW'(DEPTH));
   assign w_wr   = w_push && (!w_full || w_pop) && !trace_clear;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= {r_pc[STAGES-1], wb_reg_num, wb_data};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (trace_clear) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + PW'(1);
         if (w_pop) r_rptr <= r_rptr + PW'(1);
         r_count <= r_count + CW'(w_wr) - CW'(w_pop);
         if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   assign trace_valid    = (r_count != '0);
   assign trace_data     = r_mem[r_rptr];
   assign trace_count    = r_count;
   assign trace_overflow = r_overflow;

endmodule

// File: tb/tb_debug_trace_unit.sv
// Bench for debug_trace_unit: directed scenarios plus randomized traffic checked
// against a queue/array-based reference model.
module tb_debug_trace_unit;

   localparam int unsigned DATA  = 32;
   localparam int unsigned A     = 9;
   localparam int unsigned S     = 5;
   localparam int unsigned NB    = 2;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned TW    = A + 5 + DATA;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic              clk;
   logic              reset;
   logic              enable_debug;
   logic              stall;
   logic              flush;
   logic [A-1:0]      pc_fetch;
   logic [6:0]        opcode;
   logic [NB*A-1:0]   bp_addr;
   logic [NB-1:0]     bp_en;
   logic              resume;
   logic              wb_valid;
   logic [4:0]        wb_reg_num;
   logic [DATA-1:0]   wb_data;
   logic              trace_ready;
   logic              trace_clear;
   logic [S*A-1:0]    stage_pc;
   logic [S*7-1:0]    stage_opcode;
   logic              halt_req;
   logic [1:0]        dbg_state;
   logic [2:0]        bp_hit_idx;
   logic              trace_valid;
   logic [TW-1:0]     trace_data;
   logic [CW-1:0]     trace_count;
   logic              trace_overflow;

   debug_trace_unit #(.DATA(DATA), .ADDRESS(A), .STAGES(S), .NUM_BP(NB), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .enable_debug(enable_debug), .stall(stall), .flush(flush),
      .pc_fetch(pc_fetch), .opcode(opcode), .bp_addr(bp_addr), .bp_en(bp_en), .resume(resume),
      .wb_valid(wb_valid), .wb_reg_num(wb_reg_num), .wb_data(wb_data),
      .trace_ready(trace_ready), .trace_clear(trace_clear),
      .stage_pc(stage_pc), .stage_opcode(stage_opcode), .halt_req(halt_req),
      .dbg_state(dbg_state), .bp_hit_idx(bp_hit_idx), .trace_valid(trace_valid),
      .trace_data(trace_data), .trace_count(trace_count), .trace_overflow(trace_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model
   logic [A-1:0]  m_pc [S];
   logic [6:0]    m_op [S];
   int            m_state;
   int            m_idx;
   bit            m_mask;
   bit            m_ovf;
   logic [TW-1:0] m_q [$];

   task automatic model_reset();
      for (int k = 0; k < S; k++) begin
         m_pc[k] = '0;
         m_op[k] = '0;
      end
      m_state = 0;
      m_idx   = 0;
      m_mask  = 0;
      m_ovf   = 0;
      m_q.delete();
   endtask

   task automatic model_step();
      logic [A-1:0] npc [S];
      logic [6:0]   nop [S];
      bit adv;
      int hit;
      int nstate;
      int nidx;
      bit nmask;
      bit push;
      bit pop;
      bit full;
      adv = !stall && (m_state != 2);
      for (int k = 0; k < S; k++) begin
         npc[k] = m_pc[k];
         nop[k] = m_op[k];
      end
      if (flush) begin
         npc[0] = '0; nop[0] = '0; npc[1] = '0; nop[1] = '0;
         for (int k = 2; k < S; k++) if (adv) begin npc[k] = m_pc[k-1]; nop[k] = m_op[k-1]; end
      end else if (adv) begin
         npc[0] = pc_fetch; nop[0] = opcode;
         for (int k = 1; k < S; k++) begin npc[k] = m_pc[k-1]; nop[k] = m_op[k-1]; end
      end
      hit = -1;
      for (int i = 0; i < NB; i++)
         if (hit < 0 && bp_en[i] && pc_fetch == bp_addr[i*A +: A]) hit = i;
      nstate = m_state;
      nidx   = m_idx;
      nmask  = 0;
      if (!enable_debug) nstate = 0;
      else if (m_state == 0) nstate = 1;
      else if (m_state == 1) begin
         if (hit >= 0 && !stall && !m_mask) begin nstate = 2; nidx = hit; end
      end else if (resume) begin
         nstate = 1; nmask = 1;
      end
      push = (m_state != 0) && wb_valid && (wb_reg_num != 0);
      if (trace_clear) begin
         m_q.delete();
         m_ovf = 0;
      end else begin
         pop  = (m_q.size() > 0) && trace_ready;
         full = (m_q.size() == DEPTH);
         if (pop) void'(m_q.pop_front());
         if (push) begin
            if (!full || pop) m_q.push_back({m_pc[S-1], wb_reg_num, wb_data});
            else m_ovf = 1;
         end
      end
      for (int k = 0; k < S; k++) begin
         m_pc[k] = npc[k];
         m_op[k] = nop[k];
      end
      m_state = nstate;
      m_idx   = nidx;
      m_mask  = nmask;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < S; k++) begin
         n_checks++;
         if (stage_pc[k*A +: A] !== '0 || stage_opcode[k*7 +: 7] !== '0) begin
            n_errors++;
            $display("FAIL reset_stage[%0d]: got pc %0h op %0h expected 0", k, stage_pc[k*A +: A], stage_opcode[k*7 +: 7]);
         end
      end
      n_checks++;
      if ({dbg_state, halt_req, bp_hit_idx} !== '0) begin
         n_errors++;
         $display("FAIL reset_fsm: got state %0d halt %0b idx %0d expected 0", dbg_state, halt_req, bp_hit_idx);
      end
      n_checks++;
      if (trace_valid !== 1'b0 || trace_count !== '0 || trace_overflow !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_fifo: got valid %0b count %0d ovf %0b expected 0", trace_valid, trace_count, trace_overflow);
      end
   endtask

   task automatic test_pipeline();
      for (int i = 0; i < 5; i++) begin
         pc_fetch = A'(4 * i);
         opcode   = 7'h33;
         tick();
      end
      for (int k = 0; k < S; k++) begin
         n_checks++;
         if (stage_pc[k*A +: A] !== A'(4 * (4 - k)) || stage_opcode[k*7 +: 7] !== 7'h33) begin
            n_errors++;
            $display("FAIL pipe_stage[%0d]: got pc %0h op %0h expected pc %0h op 33", k, stage_pc[k*A +: A], stage_opcode[k*7 +: 7], 4 * (4 - k));
         end
      end
   endtask

   task automatic test_stall_flush();
      logic [A-1:0] exp_pc [S];
      stall    = 1'b1;
      pc_fetch = 9'h40;
      opcode   = 7'h13;
      tick();
      tick();
      for (int k = 0; k < S; k++) begin
         n_checks++;
         if (stage_pc[k*A +: A] !== A'(4 * (4 - k))) begin
            n_errors++;
            $display("FAIL stall_hold[%0d]: got %0h expected %0h", k, stage_pc[k*A +: A], 4 * (4 - k));
         end
      end
      stall = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_pc = '{9'd0, 9'd0, 9'd12, 9'd8, 9'd4};
      for (int k = 0; k < S; k++) begin
         n_checks++;
         if (stage_pc[k*A +: A] !== exp_pc[k] || stage_opcode[k*7 +: 7] !== ((k < 2) ? 7'h00 : 7'h33)) begin
            n_errors++;
            $display("FAIL flush_stage[%0d]: got pc %0h op %0h expected pc %0h", k, stage_pc[k*A +: A], stage_opcode[k*7 +: 7], exp_pc[k]);
         end
      end
   endtask

   task automatic test_breakpoint();
      bp_addr      = {9'h020, 9'h1FF};
      bp_en        = 2'b10;
      enable_debug = 1'b1;
      pc_fetch     = 9'h100;
      tick();
      n_checks++;
      if (dbg_state !== 2'd1) begin n_errors++; $display("FAIL bp_armed: got %0d expected 1", dbg_state); end
      pc_fetch = 9'h020;
      tick();
      n_checks++;
      if (dbg_state !== 2'd2 || halt_req !== 1'b1 || bp_hit_idx !== 3'd1) begin
         n_errors++;
         $display("FAIL bp_halt: got state %0d halt %0b idx %0d expected 2 1 1", dbg_state, halt_req, bp_hit_idx);
      end
      pc_fetch = 9'h024;
      tick();
      n_checks++;
      if (stage_pc[0 +: A] !== 9'h020 || dbg_state !== 2'd2) begin
         n_errors++;
         $display("FAIL bp_frozen: got stage0 %0h state %0d expected 20 2", stage_pc[0 +: A], dbg_state);
      end
      pc_fetch = 9'h020;
      resume   = 1'b1;
      tick();
      resume = 1'b0;
      n_checks++;
      if (dbg_state !== 2'd1 || halt_req !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_resume: got state %0d halt %0b expected 1 0", dbg_state, halt_req);
      end
      tick();
      n_checks++;
      if (dbg_state !== 2'd1 || halt_req !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_mask: got state %0d halt %0b expected 1 0", dbg_state, halt_req);
      end
      pc_fetch = 9'h024;
      tick();
   endtask

   task automatic test_trace();
      trace_ready = 1'b0;
      wb_valid    = 1'b1;
      wb_reg_num = 5'd5; wb_data = 32'hDEADBEEF; tick();
      wb_reg_num = 5'd0; wb_data = 32'h1;        tick();
      wb_reg_num = 5'd7; wb_data = 32'h12;       tick();
      wb_valid = 1'b0;
      n_checks++;
      if (trace_count !== CW'(2) || trace_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL trace_count3: got %0d valid %0b expected 2 1", trace_count, trace_valid);
      end
      n_checks++;
      if (trace_data[DATA+4:0] !== {5'd5, 32'hDEADBEEF} || trace_data !== m_q[0]) begin
         n_errors++;
         $display("FAIL trace_head: got %0h expected %0h", trace_data, m_q[0]);
      end
      trace_ready = 1'b1;
      tick();
      n_checks++;
      if (trace_data[DATA+4:0] !== {5'd7, 32'h12} || trace_count !== CW'(1)) begin
         n_errors++;
         $display("FAIL trace_pop1: got %0h count %0d expected reg 7 data 12 count 1", trace_data[DATA+4:0], trace_count);
      end
      tick();
      trace_ready = 1'b0;
      n_checks++;
      if (trace_valid !== 1'b0 || trace_count !== '0) begin
         n_errors++;
         $display("FAIL trace_drain: got valid %0b count %0d expected 0 0", trace_valid, trace_count);
      end
   endtask

   task automatic test_overflow();
      wb_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         wb_reg_num = 5'($urandom_range(1, 31));
         wb_data    = $urandom;
         tick();
      end
      n_checks++;
      if (trace_count !== CW'(16) || trace_overflow !== 1'b1) begin
         n_errors++;
         $display("FAIL ovf_full: got count %0d ovf %0b expected 16 1", trace_count, trace_overflow);
      end
      trace_ready = 1'b1;
      wb_data     = 32'hA5A5_0001;
      tick();
      n_checks++;
      if (trace_count !== CW'(16) || trace_data !== m_q[0]) begin
         n_errors++;
         $display("FAIL ovf_pushpop: got count %0d head %0h expected 16 %0h", trace_count, trace_data, m_q[0]);
      end
      wb_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (trace_valid !== 1'b1 || trace_data !== m_q[0]) begin
            n_errors++;
            $display("FAIL ovf_drain[%0d]: got %0h expected %0h", i, trace_data, m_q[0]);
         end
         tick();
      end
      trace_ready = 1'b0;
      n_checks++;
      if (trace_count !== '0 || trace_overflow !== 1'b1) begin
         n_errors++;
         $display("FAIL ovf_sticky: got count %0d ovf %0b expected 0 1", trace_count, trace_overflow);
      end
      wb_valid = 1'b1;
      repeat (3) tick();
      trace_clear = 1'b1;
      tick();
      trace_clear = 1'b0;
      wb_valid    = 1'b0;
      n_checks++;
      if (trace_count !== '0 || trace_overflow !== 1'b0 || trace_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL trace_clear: got count %0d ovf %0b expected 0 0", trace_count, trace_overflow);
      end
   endtask

   task automatic test_async_reset();
      wb_valid = 1'b1;
      wb_reg_num = 5'd9;
      repeat (4) begin wb_data = $urandom; tick(); end
      wb_valid = 1'b0;
      pc_fetch = 9'h020;
      tick();
      n_checks++;
      if (halt_req !== 1'b1 || trace_count !== CW'(4)) begin
         n_errors++;
         $display("FAIL ares_pre: got halt %0b count %0d expected 1 4", halt_req, trace_count);
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (halt_req !== 1'b0 || trace_count !== '0 || dbg_state !== 2'd0) begin
         n_errors++;
         $display("FAIL ares_mid: got halt %0b count %0d state %0d expected 0 0 0", halt_req, trace_count, dbg_state);
      end
      model_reset();
      pc_fetch = 9'h024;
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         enable_debug = ($urandom_range(0, 15) != 0);
         stall        = ($urandom_range(0, 4) == 0);
         flush        = ($urandom_range(0, 6) == 0);
         pc_fetch     = A'(32 + 4 * $urandom_range(0, 7));
         opcode       = 7'($urandom);
         bp_addr      = {A'(32 + 4 * $urandom_range(0, 7)), A'(32 + 4 * $urandom_range(0, 7))};
         bp_en        = 2'($urandom);
         resume       = ($urandom_range(0, 3) == 0);
         wb_valid     = $urandom_range(0, 1) == 1;
         wb_reg_num   = 5'($urandom_range(0, 7));
         wb_data      = $urandom;
         trace_ready  = ($urandom_range(0, 2) == 0);
         trace_clear  = ($urandom_range(0, 59) == 0);
         tick();
         for (int k = 0; k < S; k++) begin
            n_checks++;
            if (stage_pc[k*A +: A] !== m_pc[k] || stage_opcode[k*7 +: 7] !== m_op[k]) begin
               n_errors++;
               $display("FAIL rnd_stage[%0d] cyc %0d: got %0h/%0h expected %0h/%0h", k, c, stage_pc[k*A +: A], stage_opcode[k*7 +: 7], m_pc[k], m_op[k]);
            end
         end
         n_checks++;
         if (dbg_state !== 2'(m_state) || halt_req !== (m_state == 2) || bp_hit_idx !== 3'(m_idx)) begin
            n_errors++;
            $display("FAIL rnd_fsm cyc %0d: got %0d/%0b/%0d expected %0d/%0b/%0d", c, dbg_state, halt_req, bp_hit_idx, m_state, m_state == 2, m_idx);
         end
         n_checks++;
         if (trace_count !== CW'(m_q.size()) || trace_overflow !== m_ovf || trace_valid !== (m_q.size() > 0)) begin
            n_errors++;
            $display("FAIL rnd_fifo cyc %0d: got %0d/%0b expected %0d/%0b", c, trace_count, trace_overflow, m_q.size(), m_ovf);
         end
         if (m_q.size() > 0) begin
            n_checks++;
            if (trace_data !== m_q[0]) begin
               n_errors++;
               $display("FAIL rnd_head cyc %0d: got %0h expected %0h", c, trace_data, m_q[0]);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b0; enable_debug = 1'b0; stall = 1'b0; flush = 1'b0;
      pc_fetch = '0; opcode = '0; bp_addr = '0; bp_en = '0; resume = 1'b0;
      wb_valid = 1'b0; wb_reg_num = '0; wb_data = '0; trace_ready = 1'b0; trace_clear = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      test_reset();
      test_pipeline();
      test_stall_flush();
      test_breakpoint();
      test_trace();
      test_overflow();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
